digit_editor: RTL and testbench

Button-driven 4-digit decimal entry stage feeding the seven-segment display driver. Turns raw board pushbuttons into a cursor/edit state machine, presents the four BCD digits plus a one-hot blink mask for the cursor digit to the display, and on commit converts the edited number to binary for the CPU-side I/O register. The CPU can also preload the digits when the editor is idle.

---
 rtl/digit_editor.sv | 175 +++++++++++++++++
 tb/tb_digit_editor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_editor.sv
// Four-digit BCD entry editor driven by pushbuttons, with CPU preload and binary commit.
// Optional per-button debounce enabled by defining DIGIT_EDITOR_DEBOUNCE_EN.
module digit_editor #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_enter,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] digits,
  output logic [3:0]  blink,
  output logic        editing,
  output logic [13:0] value,
  output logic        value_valid,
  output logic [1:0]  dbg_state
);

  // Handshake: none; load is a level sampled every cycle in IDLE, value_valid is a one-cycle pulse.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EDIT = 2'd1, S_CONVERT = 2'd2} state_t;

  localparam int B_DOWN = 0, B_UP = 1, B_RIGHT = 2, B_LEFT = 3, B_ENTER = 4;

  logic [4:0] btn_raw;
  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0] level;
  logic [4:0] level_prev_q, level_prev_d;
  logic [4:0] pulse_q, pulse_d;

  assign btn_raw = {btn_enter, btn_left, btn_right, btn_up, btn_down};

`ifdef DIGIT_EDITOR_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];

  // Counter runs only while the synchronized level differs from the accepted one.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
        else                      cnt_d[i]    = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level = stable_q;
`else
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_unused
  end
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_prev_d = level;
    pulse_d      = level & ~level_prev_q;
  end

  state_t      state_q, state_d;
  logic [1:0]  cursor_q, cursor_d;
  logic [1:0]  k_q, k_d;
  logic [15:0] digits_q, digits_d;
  logic [13:0] acc_q, acc_d;
  logic [13:0] value_q, value_d;
  logic        value_valid_q, value_valid_d;
  logic [3:0]  cur_nib, conv_nib;

  assign cur_nib  = digits_q[{cursor_q, 2'b00} +: 4];
  assign conv_nib = digits_q[{k_q, 2'b00} +: 4];

  always_comb begin
    state_d       = state_q;
    cursor_d      = cursor_q;
    k_d           = k_q;
    digits_d      = digits_q;
    acc_d         = acc_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pulse_q[B_ENTER]) begin
          state_d  = S_EDIT;
          cursor_d = 2'd3;
        end
        if (load) begin
          for (int i = 0; i < 4; i++)
            digits_d[i*4 +: 4] = (load_value[i*4 +: 4] > 4'd9) ? 4'd0 : load_value[i*4 +: 4];
        end
      end
      S_EDIT: begin
        // Only the highest-priority pulse acts; the rest are dropped.
        if (pulse_q[B_ENTER]) begin
          state_d = S_CONVERT;
          acc_d   = '0;
          k_d     = 2'd3;
        end else if (pulse_q[B_LEFT]) begin
          cursor_d = cursor_q + 2'd1;
        end else if (pulse_q[B_RIGHT]) begin
          cursor_d = cursor_q - 2'd1;
        end else if (pulse_q[B_UP]) begin
          digits_d[{cursor_q, 2'b00} +: 4] = (cur_nib == 4'd9) ? 4'd0 : cur_nib + 4'd1;
        end else if (pulse_q[B_DOWN]) begin
          digits_d[{cursor_q, 2'b00} +: 4] = (cur_nib == 4'd0) ? 4'd9 : cur_nib - 4'd1;
        end
      end
      S_CONVERT: begin
        acc_d = acc_q * 14'd10 + {10'd0, conv_nib};
        k_d   = k_q - 2'd1;
        if (k_q == 2'd0) begin
          value_d       = acc_d;
          value_valid_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      level_prev_q  <= '0;
      pulse_q       <= '0;
      state_q       <= S_IDLE;
      cursor_q      <= 2'd3;
      k_q           <= 2'd3;
      digits_q      <= '0;
      acc_q         <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      level_prev_q  <= level_prev_d;
      pulse_q       <= pulse_d;
      state_q       <= state_d;
      cursor_q      <= cursor_d;
      k_q           <= k_d;
      digits_q      <= digits_d;
      acc_q         <= acc_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
    end
  end

  assign digits      = digits_q;
  assign editing     = (state_q == S_EDIT);
  assign blink       = (state_q == S_EDIT) ? (4'b0001 << cursor_q) : 4'b0000;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_digit_editor.sv
// Directed plus randomized bench for digit_editor against an arithmetic model of the editor.
module tb_digit_editor;

  localparam int B_DOWN = 0, B_UP = 1, B_RIGHT = 2, B_LEFT = 3, B_ENTER = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btns = '0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] digits;
  logic [3:0]  blink;
  logic        editing;
  logic [13:0] value;
  logic        value_valid;
  logic [1:0]  dbg_state;

  digit_editor #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .btn_up(btns[B_UP]), .btn_down(btns[B_DOWN]), .btn_left(btns[B_LEFT]),
    .btn_right(btns[B_RIGHT]), .btn_enter(btns[B_ENTER]),
    .load(load), .load_value(load_value),
    .digits(digits), .blink(blink), .editing(editing),
    .value(value), .value_valid(value_valid), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Behavioural model: digits as integers, cursor as an integer position, edit flag.
  int m_dig[4];
  int m_cur  = 3;
  bit m_edit = 0;

  function automatic logic [15:0] m_pack();
    return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
  endfunction

  function automatic int m_number();
    return m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
  endfunction

  function automatic void m_load(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = int'((v >> (4 * i)) & 16'hF);
      m_dig[i] = (n > 9) ? 0 : n;
    end
  endfunction

  function automatic void m_button(input int b);
    if (!m_edit) begin
      if (b == B_ENTER) begin m_edit = 1; m_cur = 3; end
    end else begin
      case (b)
        B_ENTER: m_edit = 0;
        B_LEFT:  m_cur = (m_cur + 1) % 4;
        B_RIGHT: m_cur = (m_cur + 3) % 4;
        B_UP:    m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
        B_DOWN:  m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
        default: ;
      endcase
    end
  endfunction

  // Commit monitor: cycle index, value_valid pulses, and the cycle editing drops.
  int   cyc = 0;
  int   vv_cnt = 0;
  int   vv_cyc = 0;
  int   fall_cyc = 0;
  logic edit_prev = 1'b0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (value_valid === 1'b1) begin
      vv_cnt = vv_cnt + 1;
      vv_cyc = cyc;
    end
    if (edit_prev === 1'b1 && editing === 1'b0) fall_cyc = cyc;
    edit_prev = editing;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int b);
    btns[b] = 1'b1;
    repeat (10) @(negedge clock);
    btns[b] = 1'b0;
    repeat (10) @(negedge clock);
    m_button(b);
  endtask

  task automatic chk_view(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'(m_pack()));
    chk({tag, "_blink"}, 32'(blink), m_edit ? 32'(1 << m_cur) : 32'd0);
    chk({tag, "_editing"}, 32'(editing), 32'(m_edit));
  endtask

  task automatic commit(input string tag);
    int vv0;
    int exp_val;
    vv0     = vv_cnt;
    exp_val = m_number();
    press(B_ENTER);
    chk({tag, "_pulses"}, 32'(vv_cnt), 32'(vv0 + 1));
    chk({tag, "_latency"}, 32'(vv_cyc - fall_cyc), 32'd4);
    chk({tag, "_value"}, 32'(value), 32'(exp_val));
    chk_view(tag);
  endtask

  initial begin
    int w;
    int vv0;
    logic [15:0] r;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_blink", 32'(blink), 32'h0);
    chk("rst_editing", 32'(editing), 32'h0);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_value_valid", 32'(value_valid), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);

`ifndef DIGIT_EDITOR_DEBOUNCE_EN
    // Raw rise before edge N: effect visible after edge N+3.
    btns[B_ENTER] = 1'b1;
    repeat (3) @(negedge clock);
    chk("lat_before", 32'(editing), 32'h0);
    @(negedge clock);
    chk("lat_after", 32'(editing), 32'h1);
    repeat (6) @(negedge clock);
    btns[B_ENTER] = 1'b0;
    repeat (10) @(negedge clock);
    m_button(B_ENTER);
`else
    press(B_ENTER);
`endif
    chk_view("enter_edit");

    repeat (3) press(B_UP);
    chk("up3_digits", 32'(digits), 32'h3000);

    for (int i = 0; i < 4; i++) begin
      press(B_RIGHT);
      chk_view("right");
    end
    chk("right4_blink", 32'(blink), 32'b1000);
    press(B_LEFT);
    chk("left_wrap_blink", 32'(blink), 32'b0001);

    repeat (9) press(B_UP);
    chk("d0_nine", 32'(digits), 32'h3009);
    press(B_UP);
    chk("d0_up_wrap", 32'(digits), 32'h3000);
    press(B_DOWN);
    chk("d0_down_wrap", 32'(digits), 32'h3009);

    for (int i = 0; i < 20; i++) begin
      press($urandom_range(0, 3));
      chk_view("rand_edit");
    end
    commit("commit_rand");

    load_value = 16'h12A4;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    m_load(16'h12A4);
    chk("load_digits", 32'(digits), 32'h1204);
    chk("load_keeps_value", 32'(value), 32'(vv_cnt > 0 ? value : 14'd0));

    press(B_ENTER);
    chk_view("edit_after_load");
    load_value = 16'h5555;
    load = 1'b1;
    repeat (2) @(negedge clock);
    load = 1'b0;
    chk("load_in_edit", 32'(digits), 32'h1204);
    commit("commit_1204");
    chk("commit_1204_const", 32'(value), 32'd1204);

    for (int i = 0; i < 3; i++) begin
      r = 16'($urandom);
      load_value = r;
      load = 1'b1;
      @(negedge clock);
      load = 1'b0;
      m_load(r);
      @(negedge clock);
      chk_view("rand_load");
    end

    // Enter and up together: enter wins, then reset lands mid-conversion.
    press(B_ENTER);
    chk_view("pre_sim");
    vv0 = vv_cnt;
    btns[B_ENTER] = 1'b1;
    btns[B_UP] = 1'b1;
    w = 0;
    while (editing === 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk("sim_to_convert", 32'(editing), 32'h0);
    chk("sim_no_increment", 32'(digits), 32'(m_pack()));
    btns = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_edit = 0;
    m_cur = 3;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    repeat (10) @(negedge clock);
    chk("rst_conv_no_pulse", 32'(vv_cnt), 32'(vv0));
    chk("rst_conv_value", 32'(value), 32'h0);
    chk_view("rst_conv");

    // Bouncing up button: 1-0-1 at 2-cycle spacing, then held.
    press(B_ENTER);
    btns[B_UP] = 1'b1;
    repeat (2) @(negedge clock);
    btns[B_UP] = 1'b0;
    repeat (2) @(negedge clock);
    btns[B_UP] = 1'b1;
    repeat (10) @(negedge clock);
    btns[B_UP] = 1'b0;
    repeat (10) @(negedge clock);
`ifdef DIGIT_EDITOR_DEBOUNCE_EN
    chk("bounce_digits", 32'(digits), 32'h1000);
`else
    chk("bounce_digits", 32'(digits), 32'h2000);
`endif
    chk("bounce_editing", 32'(editing), 32'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
